// File: rtl/seq_shift_mult_pkg.sv
// Shared ALU definitions: FSM state encoding and the default datapath width
// used by the sequential multiplier.
package seq_shift_mult_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_shift_mult_mult_step.sv
// One shift-and-add iteration: conditionally accumulate the multiplicand,
// then shift multiplicand left and multiplier right with zero fill.
module mult_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [2*WIDTH-1:0] mcand_nxt,
    output logic [WIDTH-1:0]   mplier_nxt
);

    always_comb begin
        acc_nxt    = mplier[0] ? (acc + mcand) : acc;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
    end

endmodule

// File: rtl/seq_shift_mult.sv
// Sequential unsigned shift-and-add multiplier: WIDTH iterations per job,
// busy/done decoded from the registered FSM state.
module seq_shift_mult
    import seq_shift_mult_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [2*WIDTH-1:0]   step_acc, step_mcand;
    logic [WIDTH-1:0]     step_mplier;

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc        (acc_q),
        .mcand      (mcand_q),
        .mplier     (mplier_q),
        .acc_nxt    (step_acc),
        .mcand_nxt  (step_mcand),
        .mplier_nxt (step_mplier)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = step_acc;
                mcand_d  = step_mcand;
                mplier_d = step_mplier;
                cnt_d    = cnt_q + 1'b1;
                // Final iteration: publish the completed sum on the same edge.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    p_d     = step_acc;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign p    = p_q;

endmodule

// File: tb/tb_seq_shift_mult.sv
// Directed bench for seq_shift_mult: scoreboard of expected products popped
// on every done pulse, plus per-cycle busy/done latency checks.
module tb_seq_shift_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a, b;
    logic        busy, done;
    logic [15:0] p;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    seq_shift_mult #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding job.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
            else                chk("product", 32'(p), 32'(sb.pop_front()));
        end
    end

    // Called at #1 after a posedge; drives start in the current cycle.
    // poke>0 re-asserts start (a=01,b=01) in that RUN cycle, then moves a to 77.
    task automatic job(input logic [7:0] ta, input logic [7:0] tb_, input int poke);
        logic [15:0] exp_p;
        exp_p = 16'(ta) * 16'(tb_);
        a = ta; b = tb_; start = 1'b1;
        sb.push_back(exp_p);
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        for (int c = 1; c <= 9; c++) begin
            if (c == poke) begin
                start = 1'b1; a = 8'h01; b = 8'h01;
            end else if (poke > 0 && c == poke + 1) begin
                start = 1'b0; a = 8'h77;
            end
            @(negedge clk);
            chk($sformatf("busy_c%0d", c), 32'(busy), 32'(1));
            chk($sformatf("done_c%0d", c), 32'(done), 32'(c == 9));
            @(posedge clk); #1;
        end
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        chk("p_hold", 32'(p), 32'(exp_p));
    endtask

    initial begin
        rst = 1'b0; start = 1'b1; a = 8'hAA; b = 8'h03;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_p", 32'(p), 32'd0);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 32'd0);

        job(8'hAA, 8'h03, 0);
        job(8'hFF, 8'hFF, 0);
        job(8'h00, 8'h5C, 0);
        job(8'h12, 8'h34, 3);
        repeat (12) @(posedge clk);
        #1;
        chk("no_second_done_busy", 32'(busy), 32'd0);

        // Abort: reset during RUN cycle 4.
        a = 8'h5A; b = 8'h3C; start = 1'b1;
        sb.push_back(16'(8'h5A) * 16'(8'h3C));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_p", 32'(p), 32'd0);
        repeat (12) @(posedge clk);
        #1;

        // Back-to-back: second start in the first IDLE cycle after done.
        job(8'h21, 8'h04, 0);
        job(8'h0D, 8'h0B, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shift_mult.md
Name: seq_shift_mult

Overview:
- Sequential unsigned shift-and-add multiplier. It is the stage directly downstream of the ALU shifter and consumes the same left-shift / right-shift primitive once per cycle.
- One multiply is accepted per start pulse. The WIDTH x WIDTH product is produced after a fixed latency, with busy and done handshake outputs.
- It sits beside the shifter in the ALU datapath and feeds the ALU result mux.

Parameters:
- WIDTH, 8, operand width in bits. Legal range is WIDTH >= 2. The product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- start  input  1  request a multiply; accepted only in IDLE
- a  input  WIDTH  multiplicand; captured on the accepting edge
- b  input  WIDTH  multiplier; captured on the accepting edge
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse marking that p holds a new result
- p  output  2*WIDTH  product register; holds its value until the next result

Behaviour:
- Reset (rst==0 at a rising edge):
  - state goes to IDLE.
  - busy=0, done=0, p=0.
  - Internal registers mcand, mplier, acc and cnt are cleared.
  - Reset overrides start and any in-flight operation. The aborted result is never presented and done does not pulse.
- FSM states are IDLE, RUN, DONE.
- IDLE, with start==1 at an edge:
  - mcand <= zero-extended a (2*WIDTH bits).
  - mplier <= b.
  - acc <= 0, cnt <= 0.
  - state <= RUN.
- IDLE, with start==0: state and registers hold.
- RUN, each edge:
  - if mplier[0]==1: acc <= acc + mcand, computed modulo 2^(2*WIDTH). No overflow is possible.
  - mcand <= mcand << 1 (logical, zero fill).
  - mplier <= mplier >> 1 (logical, zero fill).
  - cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1, state <= DONE after the final step. RUN therefore lasts exactly WIDTH cycles.
- Entering DONE: p <= final acc, registered on the same edge that enters DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - state <= IDLE on the next edge unconditionally.
- Latency: start is sampled at edge E0. RUN occupies the cycles after edges E0..E(WIDTH-1). done is high in the cycle after edge E(WIDTH).
  - For WIDTH=8, done is high in the 9th cycle after the accepting edge.
  - The minimum start-to-start spacing is WIDTH+2 cycles.
- Ignored events:
  - start while busy (RUN or DONE) is ignored and is not queued.
  - Changes on a and b after the accepting edge have no effect.
- p is stable outside the DONE-entry edge. A zero operand still runs the full WIDTH cycles, with no early termination.
- Counter: cnt is $clog2(WIDTH) bits wide and is reset to 0 on every accept.
- done and busy are registered-state decodes: busy = (state != IDLE), done = (state == DONE). Neither output has a combinational path from the inputs.

Decomposition:
- Shared ALU package holds:
  - the state encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - a default width constant ALU_WIDTH=8, which is used as WIDTH.
- One sub-module, mult_step. It is purely combinational and parameterised by WIDTH.
  - Inputs: acc, mcand, mplier.
  - Outputs: next acc, the shifted mcand, the shifted mplier.
  - It reuses the shifter's left/right shift convention.
- The top level holds the FSM, cnt, the registers and the handshake.

Test Plan:
- Reset with rst=0 for 2 cycles, then release -> busy=0, done=0, p=16'h0000. A start pulse applied while rst=0 is ignored.
- a=8'hAA, b=8'h03, start for 1 cycle -> busy=1 for 9 cycles. done pulses high exactly 1 cycle, 9 cycles after the accept edge. p=16'h01FE, and p holds afterwards.
- a=8'hFF, b=8'hFF -> p=16'hFE01. Then a=8'h00, b=8'h5C -> p=16'h0000 with the same full latency.
- Re-assert start on the 3rd cycle of RUN with a=8'h01, b=8'h01, and change a to 8'h77 mid-run -> the original product is unaffected, there is no second done, and busy deasserts on schedule.
- rst=0 for one edge during cycle 4 of RUN -> next cycle shows busy=0, done=0, p=0, and no done pulse ever appears for the aborted job.
- Back-to-back: assert start in the first IDLE cycle after done (a=8'h0D, b=8'h0B) -> accepted, and p=16'h008F after 9 cycles.
